// File: rtl/button_debouncer.sv
// Button/switch debouncer: multi-flop synchronizer, four-state stability checker,
// registered debounced level, one-cycle edge strobes and an 8-bit press counter.
module button_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       db_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] press_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_out_q, db_out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             press_count_q, press_count_d;

  // Synchronizer chain: btn_in enters at bit 0, the oldest sample exits at the top.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // State register together with the stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a level change is accepted after STABLE_CYCLES agreeing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (sync_out) begin
          state_d = ST_CHK_H;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_H: begin
        if (!sync_out) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_CHK_H;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync_out) begin
          state_d = ST_CHK_L;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_L: begin
        if (sync_out) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_CHK_L;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output logic is decoded from the next state so db_out moves on the accepting edge.
  always_comb begin
    db_out_d      = (state_d == ST_HIGH) || (state_d == ST_CHK_L);
    rise_d        = (state_q == ST_CHK_H) && (state_d == ST_HIGH);
    fall_d        = (state_q == ST_CHK_L) && (state_d == ST_LOW);
    press_count_d = press_count_q;
    if (rise_d) begin
      press_count_d = press_count_q + 8'd1;
    end else begin
      press_count_d = press_count_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_out_q      <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      db_out_q      <= db_out_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      press_count_q <= press_count_d;
    end
  end

  assign db_out      = db_out_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_count = press_count_q;

endmodule
